// File: rtl/excpt_req_ctrl.sv
// Exception/interrupt request controller: edge capture into pending, mask and
// global enable, fixed-priority selection and the request/ack/iret handshake.
module excpt_req_ctrl #(
   parameter  int NUM_EXC = 16,
   localparam int ID_SIZE = $clog2(NUM_EXC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_EXC-1:0] irq_in,
   input  logic               global_en,
   input  logic               mask_we,
   input  logic [NUM_EXC-1:0] mask_wdata,
   input  logic               cpu_ack,
   input  logic               cpu_iret,
   output logic               irq_req,
   output logic [NUM_EXC-1:0] excpt_en,
   output logic               in_service,
   output logic [ID_SIZE-1:0] active_id,
   output logic [NUM_EXC-1:0] pending,
   output logic [NUM_EXC-1:0] mask
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [NUM_EXC-1:0] pending_q, pending_d;
   logic [NUM_EXC-1:0] mask_q, mask_d;
   logic [NUM_EXC-1:0] irq_prev_q;
   logic [NUM_EXC-1:0] sel_q, sel_d;
   logic [ID_SIZE-1:0] id_q, id_d;
   logic               armed_q;
   logic [NUM_EXC-1:0] set_s, clr_s, elig_s;

   function automatic logic [ID_SIZE-1:0] lowest_idx(input logic [NUM_EXC-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_EXC - 1; i >= 0; i--) begin
         if (v[i]) begin
            lowest_idx = ID_SIZE'(i);
         end
      end
   endfunction

   // The first sample after reset only establishes the edge baseline, so a
   // source held high through reset must toggle before it is recognised.
   assign set_s  = (irq_in & ~irq_prev_q) & {NUM_EXC{armed_q}};
   assign elig_s = pending_q & mask_q;

   // Next state for the handshake FSM, selection, pending and mask.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      id_d      = id_q;
      clr_s     = '0;
      mask_d    = mask_q;
      case (state_q)
         ST_IDLE: begin
            if (global_en && (elig_s != '0)) begin
               id_d    = lowest_idx(elig_s);
               sel_d   = {{(NUM_EXC-1){1'b0}}, 1'b1} << lowest_idx(elig_s);
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (cpu_ack) begin
               clr_s   = sel_q;
               state_d = ST_SERVICE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_SERVICE: begin
            if (cpu_iret) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SERVICE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (mask_we) begin
         mask_d = mask_wdata;
      end else begin
         mask_d = mask_q;
      end
      // Set after clear, so a new edge on the acknowledged bit survives.
      pending_d = (pending_q & ~clr_s) | set_s;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         mask_q     <= '0;
         irq_prev_q <= '0;
         sel_q      <= '0;
         id_q       <= '0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         irq_prev_q <= irq_in;
         sel_q      <= sel_d;
         id_q       <= id_d;
         armed_q    <= 1'b1;
      end
   end

   assign irq_req    = (state_q == ST_REQ);
   assign in_service = (state_q == ST_SERVICE);
   assign excpt_en   = (state_q == ST_REQ) ? sel_q : '0;
   assign active_id  = id_q;
   assign pending    = pending_q;
   assign mask       = mask_q;

endmodule

// File: tb/tb_excpt_req_ctrl.sv
// Bench for excpt_req_ctrl: directed scenarios plus random traffic, all
// checked against a behavioural model of pending/mask/handshake rules.
module tb_excpt_req_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] irq_in = 16'h0000;
   logic        global_en = 1'b0;
   logic        mask_we = 1'b0;
   logic [15:0] mask_wdata = 16'h0000;
   logic        cpu_ack = 1'b0;
   logic        cpu_iret = 1'b0;
   logic        irq_req;
   logic [15:0] excpt_en;
   logic        in_service;
   logic [3:0]  active_id;
   logic [15:0] pending;
   logic [15:0] mask;

   int n_cmp = 0;
   int n_err = 0;

   // Model: request phase is one of "waiting", "requesting", "serving".
   localparam int WAITING    = 0;
   localparam int REQUESTING = 1;
   localparam int SERVING    = 2;
   int          m_phase;
   int          m_id;
   logic [15:0] m_pend, m_mask, m_prev;
   bit          m_fresh;

   excpt_req_ctrl dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .global_en(global_en),
      .mask_we(mask_we), .mask_wdata(mask_wdata), .cpu_ack(cpu_ack),
      .cpu_iret(cpu_iret), .irq_req(irq_req), .excpt_en(excpt_en),
      .in_service(in_service), .active_id(active_id), .pending(pending),
      .mask(mask)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int first_set(input logic [15:0] v);
      for (int i = 0; i < 16; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = WAITING;
      m_id    = 0;
      m_pend  = 16'h0000;
      m_mask  = 16'h0000;
      m_prev  = 16'h0000;
      m_fresh = 1'b1;
   endtask

   // One clock edge of the reference, using the inputs currently driven.
   task automatic model_step();
      logic [15:0] rise, drop, elig;
      rise = m_fresh ? 16'h0000 : (irq_in & ~m_prev);
      drop = 16'h0000;
      elig = m_pend & m_mask;
      if (m_phase == REQUESTING && cpu_ack) begin
         drop    = 16'h0001 << m_id;
         m_phase = SERVING;
      end else if (m_phase == SERVING && cpu_iret) begin
         m_phase = WAITING;
      end else if (m_phase == WAITING && global_en && elig != 16'h0000) begin
         m_id    = first_set(elig);
         m_phase = REQUESTING;
      end
      m_pend  = (m_pend & ~drop) | rise;
      if (mask_we) m_mask = mask_wdata;
      m_prev  = irq_in;
      m_fresh = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk_eq({tag, ".irq_req"},    32'(irq_req),    32'(m_phase == REQUESTING));
      chk_eq({tag, ".excpt_en"},   32'(excpt_en),   (m_phase == REQUESTING) ? (32'h1 << m_id) : 32'h0);
      chk_eq({tag, ".in_service"}, 32'(in_service), 32'(m_phase == SERVING));
      chk_eq({tag, ".active_id"},  32'(active_id),  32'(m_id));
      chk_eq({tag, ".pending"},    32'(pending),    32'(m_pend));
      chk_eq({tag, ".mask"},       32'(mask),       32'(m_mask));
   endtask

   task automatic cycle(input logic [15:0] irq, input logic gen, input logic mwe,
                        input logic [15:0] mwd, input logic ack, input logic iret,
                        input string tag);
      @(negedge clk);
      irq_in = irq; global_en = gen; mask_we = mwe; mask_wdata = mwd;
      cpu_ack = ack; cpu_iret = iret;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // 1: single source, two-cycle request latency
      cycle(16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, "t1_mask");
      cycle(16'h0020, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t1_edge");
      chk_eq("t1_pend", 32'(pending), 32'h0020);
      chk_eq("t1_noreq_yet", 32'(irq_req), 32'h0);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t1_req");
      chk_eq("t1_irq_req", 32'(irq_req), 32'h1);
      chk_eq("t1_excpt_en", 32'(excpt_en), 32'h0020);
      chk_eq("t1_id", 32'(active_id), 32'h5);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "t1_ack");
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "t1_iret");

      // 2: simultaneous edges, priority and re-request after iret
      cycle(16'h0208, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t2_edge");
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t2_req");
      chk_eq("t2_excpt_en", 32'(excpt_en), 32'h0008);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "t2_ack");
      chk_eq("t2_pend", 32'(pending), 32'h0200);
      chk_eq("t2_insvc", 32'(in_service), 32'h1);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "t2_iret");
      chk_eq("t2_gap", 32'(irq_req), 32'h0);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t2_rereq");
      chk_eq("t2_excpt_en2", 32'(excpt_en), 32'h0200);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "t2_ack2");
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "t2_iret2");

      // 3: masked source pends, requested once unmasked
      cycle(16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, "t3_mask0");
      cycle(16'h0004, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t3_edge");
      chk_eq("t3_pend", 32'(pending), 32'h0004);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t3_masked");
      chk_eq("t3_noreq", 32'(irq_req), 32'h0);
      cycle(16'h0000, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b0, "t3_unmask");
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t3_req");
      chk_eq("t3_irq_req", 32'(irq_req), 32'h1);
      cycle(16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, "t3_ack");
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "t3_iret");

      // 4: selection frozen in REQ; no nesting
      cycle(16'h0080, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t4_edge7");
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t4_req7");
      cycle(16'h0002, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, "t4_edge1");
      chk_eq("t4_frozen", 32'(excpt_en), 32'h0080);
      cycle(16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, "t4_ack");
      chk_eq("t4_pend", 32'(pending), 32'h0002);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t4_svc");
      chk_eq("t4_nonest", 32'(irq_req), 32'h0);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "t4_iret");
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t4_req1");
      chk_eq("t4_excpt_en1", 32'(excpt_en), 32'h0002);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "t4_ack1");
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "t4_iret1");

      // 5: ignored handshakes and global_en gating
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "t5_ack_idle");
      chk_eq("t5_idle_ack", 32'(in_service), 32'h0);
      cycle(16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "t5_edge");
      cycle(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "t5_gated");
      chk_eq("t5_gen0", 32'(irq_req), 32'h0);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t5_req");
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "t5_iret_req");
      chk_eq("t5_still_req", 32'(irq_req), 32'h1);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, "t5_ack_iret");
      chk_eq("t5_acked", 32'(in_service), 32'h1);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, "t5_iret");

      // 6: async reset mid-service, source held high through reset
      cycle(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t6_edge");
      cycle(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t6_req");
      cycle(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "t6_ack");
      cycle(16'h0030, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t6_pend5");
      #2 rst = 1'b1;
      #1;
      chk_eq("t6_rst_insvc", 32'(in_service), 32'h0);
      chk_eq("t6_rst_pend", 32'(pending), 32'h0);
      chk_eq("t6_rst_id", 32'(active_id), 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, "t6_held0");
      cycle(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t6_held1");
      cycle(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t6_held2");
      chk_eq("t6_noedge", 32'(irq_req), 32'h0);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t6_low");
      cycle(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t6_rise");
      chk_eq("t6_pend4", 32'(pending), 32'h0010);
      cycle(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, "t6_req4");
      chk_eq("t6_excpt_en", 32'(excpt_en), 32'h0010);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         cycle(16'($urandom & $urandom & $urandom),
               1'($urandom_range(0, 7) != 0),
               1'($urandom_range(0, 15) == 0),
               16'($urandom),
               1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 2) == 0),
               "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
